// File: rtl/load_store_unit.sv
// Load/store unit between a core and a 32-bit word-addressed synchronous data memory.
// Handles byte/half/word accesses, sub-word stores by read-modify-write, and rejects misaligned requests.
module load_store_unit #(
    parameter int WORD_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        mem_read,
    output logic        mem_write
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CAPT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t                state;
    logic                  we_q;
    logic                  sign_q;
    logic [1:0]            size_q;
    logic [WORD_IDX_W+1:0] addr_q;
    logic [31:0]           wbuf;

    // Address bits above the memory window are deliberately ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:WORD_IDX_W+2];

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   return sx ? 32'(signed'(b)) : {24'b0, b};
            2'b01:   return sx ? 32'(signed'(h)) : {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] ins;
        case (sz)
            2'b00: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                ins  = {24'b0, data[7:0]} << {off, 3'b000};
            end
            2'b01: begin
                mask = off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                ins  = off[1] ? {data[15:0], 16'b0} : {16'b0, data[15:0]};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = data;
            end
        endcase
        return (word & ~mask) | (ins & mask);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wbuf     <= 32'b0;
            rdata    <= 32'b0;
            done     <= 1'b0;
            misalign <= 1'b0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (is_misaligned(size, addr[1:0])) begin
                            misalign <= 1'b1;
                        end else begin
                            we_q   <= we;
                            sign_q <= sign_ext;
                            size_q <= size;
                            addr_q <= addr[WORD_IDX_W+1:0];
                            // Store data parks in the write buffer; sub-word stores merge into it later.
                            if (we) begin
                                wbuf <= wdata;
                            end
                            state <= (we && size[1]) ? WRITE : READ;
                        end
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    if (we_q) begin
                        wbuf  <= merge_lane(mem_read_data, wbuf, size_q, addr_q[1:0]);
                        state <= WRITE;
                    end else begin
                        rdata <= extract_lane(mem_read_data, size_q, addr_q[1:0], sign_q);
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign mem_read       = (state == READ);
    assign mem_write      = (state == WRITE);
    assign mem_address    = {{(32-WORD_IDX_W){1'b0}}, addr_q[WORD_IDX_W+1:2]};
    assign mem_write_data = wbuf;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: random and directed accesses against a byte-array reference model,
// with a scoreboard monitor checking memory traffic, done/misalign events, latency and rdata.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, misalign, mem_read, mem_write;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

    load_store_unit #(.WORD_IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
        .rdata(rdata), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read(mem_read), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous data memory seen by the DUT.
    logic [31:0] phys [32];
    logic [31:0] init_words [32];
    logic        load_mem;
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 32; i++) phys[i] <= init_words[i];
        end else begin
            if (mem_write) phys[mem_address[4:0]] <= mem_write_data;
            if (mem_read) mem_read_data <= phys[mem_address[4:0]];
        end
    end

    // Reference model: 128-byte memory plus last load result.
    logic [7:0]  ref_b [128];
    logic [31:0] ref_rdata;

    typedef struct {
        int          kind;   // 0 load, 1 store, 2 misaligned, 3 abandoned by reset
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] idx;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] ref_word(int wi);
        logic [31:0] v = 0;
        for (int k = 0; k < 4; k++) v = v + (32'(ref_b[wi*4+k]) << (8*k));
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && !load_mem) begin
            chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (mem_read || mem_write) begin
                if (sb.size() == 0) begin
                    chk("unexpected_mem_access", 32'd1, 32'd0);
                end else begin
                    chk("mem_address", mem_address, sb[0].idx);
                    if (mem_read) chk("read_allowed", 32'(sb[0].kind != 2), 32'd1);
                    if (mem_write) begin
                        chk("write_is_store", 32'(sb[0].kind == 1), 32'd1);
                        chk("mem_write_data", mem_write_data, sb[0].wd);
                    end
                end
            end
            if (done || misalign) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done", 32'(done), 32'(e.kind != 2));
                    chk("misalign", 32'(misalign), 32'(e.kind == 2));
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("rdata", rdata, e.rd);
                    chk("busy_at_event", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n = 0;
        int   ba, nb;
        logic [31:0] v;
        @(negedge clk);
        while (busy && n < 20) begin
            // Junk requests while busy must be ignored.
            req  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = $urandom;
            @(negedge clk);
            n++;
        end
        if (busy) begin
            chk("busy_timeout", 32'(busy), 32'd0);
            return;
        end
        we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
        ba = int'(a % 32'd128);
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.idx = 32'(ba / 4);
        e.acc = cyc;
        e.wd  = 32'd0;
        if (ba % nb != 0) begin
            e.kind = 2; e.lat = 1; e.rd = ref_rdata;
        end else if (!w) begin
            v = 0;
            for (int k = 0; k < nb; k++) v = v + (32'(ref_b[ba+k]) << (8*k));
            if (sx && nb < 4 && v >= (32'd1 << (8*nb-1))) v = v - (32'd1 << (8*nb));
            ref_rdata = v;
            e.kind = 0; e.lat = 3; e.rd = v;
        end else begin
            for (int k = 0; k < nb; k++) ref_b[ba+k] = 8'(d >> (8*k));
            e.kind = 1; e.lat = (nb == 4) ? 2 : 4; e.rd = ref_rdata;
            e.wd = ref_word(ba / 4);
        end
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        req = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_misalign"}, 32'(misalign), 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_mem_address"}, mem_address, 32'd0);
        chk({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [31:0] a;
        logic [1:0]  sz;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = 32'd0; wdata = 32'd0; load_mem = 1'b1; ref_rdata = 32'd0;
        for (int i = 0; i < 32; i++) begin
            init_words[i] = (i == 3) ? 32'h8899AABB : $urandom;
            for (int k = 0; k < 4; k++) ref_b[i*4+k] = 8'(init_words[i] >> (8*k));
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        load_mem = 1'b0;
        rst_n = 1'b1;

        // Directed scenarios.
        issue(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'd0);
        issue(1'b0, 2'd0, 1'b1, 32'h0000_000E, 32'd0);
        issue(1'b0, 2'd0, 1'b0, 32'h0000_000E, 32'd0);
        issue(1'b1, 2'd1, 1'b0, 32'h0000_000C, 32'h0000_1234);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_000D, 32'd0);
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0080, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0);
        drain();
        chk("word3_after_half_store", phys[3], 32'h88991234);
        chk("word0_after_wrap_store", phys[0], 32'hDEADBEEF);

        // Randomized traffic, mostly aligned, with occasional idle gaps.
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a & ~32'd1;
                else if (sz >= 2'd2) a = a & ~32'd3;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) drain();
        end
        drain();

        // Reset in the CAPT cycle of a byte store must abandon it.
        @(negedge clk);
        we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h0000_0021; wdata = 32'h0000_0055; req = 1'b1;
        e.kind = 3; e.rd = ref_rdata; e.wd = 32'd0; e.idx = 32'd8; e.acc = cyc; e.lat = 0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        sb.delete();
        ref_rdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int i = 0; i < 32; i++) chk($sformatf("mem_word_%0d", i), phys[i], ref_word(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WORD_IDX_W, default 5, meaning the width of the word index driven to the data memory (32 words).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  1  access request, sampled only while busy=0.
REQ-005 SHALL have port we  input  1  1=store, 0=load.
REQ-006 SHALL have port size  input  2  access size: 00=byte, 01=half, 10=word; 11 is treated as word.
REQ-007 SHALL have port sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-008 SHALL have port addr  input  32  byte address.
REQ-009 SHALL have port wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking access completion.
REQ-012 SHALL have port misalign  output  1  one-cycle pulse marking a rejected misaligned request.
REQ-013 SHALL have port rdata  output  32  extended load result.
REQ-014 SHALL have ports mem_address  output  32 (word index in [WORD_IDX_W-1:0], upper bits 0); mem_write_data  output  32; mem_read_data  input  32; mem_read  output  1; mem_write  output  1.

Function
REQ-015 SHALL use the FSM states IDLE, READ, CAPT and WRITE, with mem_read=1 only in READ and mem_write=1 only in WRITE, both decoded directly from the state flops.
REQ-016 SHALL, in IDLE with req=1 and an aligned address, latch we, size, sign_ext, addr and wdata at posedge and go to WRITE for a word store, otherwise to READ.
REQ-017 SHALL treat a request as misaligned when it is a half with addr[0]=1 or a word with addr[1:0]!=0; such a request pulses misalign in the next cycle, stays in IDLE, makes no memory access and does not pulse done.
REQ-018 SHALL drive mem_address = addr[WORD_IDX_W+1:2] from the latched address, ignoring addr[31:WORD_IDX_W+2] so that accesses wrap at 128 bytes.
REQ-019 SHALL go READ -> CAPT unconditionally, because the memory registers read data on the READ posedge.
REQ-020 SHALL, in CAPT on a load, register rdata as the extracted lane, pulse done in the next cycle and return to IDLE.
REQ-021 SHALL, in CAPT on a sub-word store, register the merged word (read word with only the target lane replaced by wdata) into the write buffer and go to WRITE.
REQ-022 SHALL, in WRITE, drive mem_write_data from the write buffer (a word store uses wdata unmodified), pulse done in the next cycle and return to IDLE.
REQ-023 SHALL use little-endian lanes: byte k=addr[1:0] occupies bits [8k+7:8k]; the half-word lane is selected by addr[1].
REQ-024 SHALL give latency from the accepting edge to the done pulse of 3 cycles for loads, 2 for word stores and 4 for byte/half stores.
REQ-025 SHALL ignore req while busy=1, and SHALL accept a new req in the same cycle that done is high (back-to-back).
REQ-026 SHALL hold rdata until the next load completes; stores and misaligned requests leave rdata unchanged.
REQ-027 SHALL never assert mem_read and mem_write in the same cycle.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=IDLE, busy=0, done=0, misalign=0, mem_read=0, mem_write=0, rdata=0, mem_address=0, mem_write_data=0 and the write buffer to 0.
REQ-029 SHALL, when reset is asserted mid-access, abandon the access with no subsequent memory write and no done pulse, even if a store was in WRITE.

Verification
REQ-030 SHALL cover a word load: memory word 3 = 0x8899AABB, load word at addr 0x0C -> mem_read high 1 cycle, done 3 cycles after accept, rdata=0x8899AABB.
REQ-031 SHALL cover a byte load with sign: same word, byte load at addr 0x0E, sign_ext=1 -> rdata=0xFFFFFF99; with sign_ext=0 -> rdata=0x00000099.
REQ-032 SHALL cover a half store read-modify-write: word 3 = 0x8899AABB, store half 0x1234 at addr 0x0C -> READ, CAPT and WRITE sequence, mem_write_data=0x88991234, done 4 cycles after accept.
REQ-033 SHALL cover misalignment: word load at addr 0x0D -> misalign pulse, no mem_read, busy stays 0, rdata unchanged.
REQ-034 SHALL cover back-to-back accesses and wrap: word store 0xDEADBEEF at addr 0x80 followed by req in the done cycle loading addr 0x00 -> mem_address=0 for both, rdata=0xDEADBEEF.
REQ-035 SHALL cover reset during a byte store: rst_n low in CAPT -> mem_write never asserted, memory word unchanged, all outputs 0.
